// File: rtl/tft_arbiter.sv
// tft_arbiter: shares one TFT byte transmitter among N_REQ byte-stream
// requesters. Port 0 has strict priority; ports 1..N_REQ-1 are served
// round-robin. A grant covers a whole burst (through the byte flagged last),
// and a watchdog takes the grant back from a requester that stalls mid-burst.
module tft_arbiter #(
  parameter int N_REQ   = 3,
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ-1:0]   req_dc,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   grant,
  input  logic               tft_busy,
  output logic               tft_dc,
  output logic [7:0]         tft_data,
  output logic               tft_transmit,
  output logic               active,
  output logic               timeout_err
);

  localparam int PW = $clog2(N_REQ);
  // Counter value at which the next idle cycle completes the timeout.
  localparam logic [CNT_W-1:0] TMO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {ARB, SEND, XMIT, GAP} state_t;

  state_t           r_state, w_state;
  logic [N_REQ-1:0] r_grant, w_grant, w_pick;
  logic [PW-1:0]    r_ptr, w_ptr, w_ptr_adv;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic             r_dc, w_dc;
  logic [7:0]       r_data, w_data;
  logic             r_last, w_last;
  logic             r_tmo, w_tmo;
  logic             w_found;
  logic             w_gvalid, w_gdc, w_glast, w_accept;
  logic [7:0]       w_gdata;

  // Arbitration pick: port 0 first, then search upward from r_ptr, wrapping to 1.
  always_comb begin
    w_pick  = '0;
    w_found = 1'b0;
    if (req_valid[0]) begin
      w_pick[0] = 1'b1;
      w_found   = 1'b1;
    end else begin
      for (int i = 1; i < N_REQ; i++) begin
        if (!w_found && req_valid[i] && (i >= int'(r_ptr))) begin
          w_pick[i] = 1'b1;
          w_found   = 1'b1;
        end
      end
      for (int i = 1; i < N_REQ; i++) begin
        if (!w_found && req_valid[i] && (i < int'(r_ptr))) begin
          w_pick[i] = 1'b1;
          w_found   = 1'b1;
        end
      end
    end
  end

  // Select the owner's request lines and the pointer value used on release.
  always_comb begin
    w_gvalid  = 1'b0;
    w_gdc     = 1'b0;
    w_glast   = 1'b0;
    w_gdata   = '0;
    w_ptr_adv = r_ptr;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_grant[i]) begin
        w_gvalid = req_valid[i];
        w_gdc    = req_dc[i];
        w_glast  = req_last[i];
        w_gdata  = req_data[i*8 +: 8];
        // Releasing port 0 leaves the round-robin pointer alone.
        if (i != 0) w_ptr_adv = (i == N_REQ-1) ? PW'(1) : PW'(i + 1);
      end
    end
  end

  assign w_accept = (r_state == SEND) && w_gvalid && !tft_busy;

  // Next-state and datapath updates.
  always_comb begin
    w_state = r_state;
    w_grant = r_grant;
    w_ptr   = r_ptr;
    w_cnt   = r_cnt;
    w_dc    = r_dc;
    w_data  = r_data;
    w_last  = r_last;
    w_tmo   = 1'b0;
    case (r_state)
      ARB: begin
        if (w_found) begin
          w_grant = w_pick;
          w_cnt   = '0;
          w_state = SEND;
        end
      end
      SEND: begin
        if (w_accept) begin
          w_dc    = w_gdc;
          w_data  = w_gdata;
          w_last  = w_glast;
          w_cnt   = '0;
          w_state = XMIT;
        end else if ((TIMEOUT != 0) && !w_gvalid) begin
          // Busy with a valid byte waiting is not a stall; only missing data counts.
          if (r_cnt == TMO_LAST) begin
            w_tmo   = 1'b1;
            w_grant = '0;
            w_ptr   = w_ptr_adv;
            w_cnt   = '0;
            w_state = ARB;
          end else begin
            w_cnt = r_cnt + CNT_W'(1);
          end
        end
      end
      XMIT: w_state = GAP;
      GAP: begin
        // tft_busy is not looked at here: the transmitter needs this cycle to raise it.
        if (r_last) begin
          w_grant = '0;
          w_ptr   = w_ptr_adv;
          w_state = ARB;
        end else begin
          w_state = SEND;
        end
      end
      default: w_state = ARB;
    endcase
  end

  // State registers; reset aborts any burst and drops a pending transmit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ARB;
      r_grant <= '0;
      r_ptr   <= PW'(1);
      r_cnt   <= '0;
      r_dc    <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_grant <= w_grant;
      r_ptr   <= w_ptr;
      r_cnt   <= w_cnt;
      r_dc    <= w_dc;
      r_data  <= w_data;
      r_last  <= w_last;
      r_tmo   <= w_tmo;
    end
  end

  assign req_ready    = ((r_state == SEND) && !tft_busy) ? r_grant : '0;
  assign grant        = r_grant;
  assign active       = |r_grant;
  assign tft_transmit = (r_state == XMIT);
  assign tft_dc       = r_dc;
  assign tft_data     = r_data;
  assign timeout_err  = r_tmo;

endmodule

// File: tb/tb_tft_arbiter.sv
// Bench for tft_arbiter: requester queues drive the DUT, a cycle reference
// built from owner/phase/countdown bookkeeping predicts every output, and
// directed scenarios add timing and ordering checks on a transmit log.
module tb_tft_arbiter;

  localparam int N   = 3;
  localparam int TMO = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid, req_dc, req_last, req_ready, grant;
  logic [8*N-1:0] req_data;
  logic           tft_busy, tft_dc, tft_transmit, active, timeout_err;
  logic [7:0]     tft_data;

  tft_arbiter #(.N_REQ(N), .TIMEOUT(TMO), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_dc(req_dc),
    .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .grant(grant), .tft_busy(tft_busy), .tft_dc(tft_dc), .tft_data(tft_data),
    .tft_transmit(tft_transmit), .active(active), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic dc; logic [7:0] data; logic last;} byte_t;
  typedef struct {int c; int own; logic dc; logic [7:0] data;} tx_t;

  byte_t q [N][$];
  tx_t   txlog[$];
  int    tmolog[$];
  int    hold[N];
  bit    acc[N];
  int    n_chk = 0, n_fail = 0, cyc_n = 0;
  int    busy_mode = 0, bcnt = 0;
  bit    rnd_hold = 0, tx_seen = 0;

  // Reference state: owner index (-1 idle), phase countdown (2 = transmit
  // cycle, 1 = gap cycle, 0 = may accept), rr pointer, stall count.
  int         m_owner, m_ph, m_ptr, m_idle;
  bit         m_last, m_tmo;
  logic       m_dc;
  logic [7:0] m_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int oh2i(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  function automatic int pick(input logic [N-1:0] v);
    if (v[0]) return 0;
    for (int k = 0; k < N-1; k++) begin
      int i;
      i = ((m_ptr - 1 + k) % (N - 1)) + 1;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic int adv(input int o);
    if (o == 0) return m_ptr;
    return (o == N-1) ? 1 : o + 1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_ph = 0; m_ptr = 1; m_idle = 0;
    m_last = 0; m_tmo = 0; m_dc = 1'b0; m_data = 8'h00;
    bcnt = 0;
    for (int i = 0; i < N; i++) begin hold[i] = 0; acc[i] = 0; q[i].delete(); end
    req_valid = '0; req_dc = '0; req_last = '0; req_data = '0; tft_busy = 1'b0;
  endtask

  // Compare this cycle's outputs against the reference prediction.
  task automatic check_cycle();
    logic [N-1:0] eg, er;
    logic         etx;
    eg  = (m_owner < 0) ? '0 : N'(1 << m_owner);
    etx = (m_owner >= 0) && (m_ph == 2);
    er  = ((m_owner >= 0) && (m_ph == 0) && !tft_busy) ? eg : '0;
    chk("grant",       32'(grant),        32'(eg));
    chk("req_ready",   32'(req_ready),    32'(er));
    chk("tft_transmit",32'(tft_transmit), 32'(etx));
    chk("active",      32'(active),       32'(eg != '0));
    chk("timeout_err", 32'(timeout_err),  32'(m_tmo));
    chk("tft_dc",      32'(tft_dc),       32'(m_dc));
    chk("tft_data",    32'(tft_data),     32'(m_data));
    tx_seen = tft_transmit;
    if (tft_transmit) txlog.push_back('{cyc_n, oh2i(grant), tft_dc, tft_data});
    if (timeout_err) tmolog.push_back(cyc_n);
  endtask

  task automatic model_step();
    bit nt;
    nt = 0;
    for (int i = 0; i < N; i++) acc[i] = 0;
    if (m_owner < 0) begin
      int p;
      p = pick(req_valid);
      if (p >= 0) begin m_owner = p; m_ph = 0; m_idle = 0; end
    end else if (m_ph == 2) begin
      m_ph = 1;
    end else if (m_ph == 1) begin
      if (m_last) begin m_ptr = adv(m_owner); m_owner = -1; end
      else m_ph = 0;
    end else if (req_valid[m_owner] && !tft_busy) begin
      m_dc = q[m_owner][0].dc; m_data = q[m_owner][0].data; m_last = q[m_owner][0].last;
      acc[m_owner] = 1; m_ph = 2; m_idle = 0;
    end else if (!req_valid[m_owner]) begin
      m_idle++;
      if (m_idle == TMO) begin nt = 1; m_ptr = adv(m_owner); m_owner = -1; m_idle = 0; end
    end
    m_tmo = nt;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        void'(q[i].pop_front());
        req_valid[i] = 1'b0;
        hold[i] = !rnd_hold ? 0 :
                  ($urandom_range(0, 19) == 0) ? int'($urandom_range(9, 12)) : int'($urandom_range(0, 2));
      end
      if (!req_valid[i]) begin
        if (hold[i] > 0) hold[i]--;
        else if (q[i].size() > 0) begin
          req_valid[i] = 1'b1;
          req_dc[i]    = q[i][0].dc;
          req_last[i]  = q[i][0].last;
          req_data[i*8 +: 8] = q[i][0].data;
        end
      end
    end
    case (busy_mode)
      1: begin
        if (tx_seen) bcnt = 20;
        if (bcnt > 0) begin tft_busy = 1'b1; bcnt--; end else tft_busy = 1'b0;
      end
      2:       tft_busy = ($urandom_range(0, 3) == 0);
      default: tft_busy = 1'b0;
    endcase
  endtask

  task automatic cyc();
    @(negedge clk);
    check_cycle();
    model_step();
    @(posedge clk);
    #1;
    cyc_n++;
    drive();
  endtask

  function automatic bit busy_any();
    for (int i = 0; i < N; i++) if (q[i].size() > 0) return 1;
    return (m_owner >= 0) || (req_valid != '0);
  endfunction

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while (busy_any() && n < budget) begin cyc(); n++; end
    if (n >= budget) chk("drain_budget", 32'(n), 32'(0));
  endtask

  task automatic burst(input int r, input int len, input logic [7:0] base);
    for (int j = 0; j < len; j++) q[r].push_back('{(j != 0), base + 8'(j), (j == len-1)});
  endtask

  initial begin
    rst = 1'b0;
    model_reset();
    #12;
    chk("rst_grant",  32'(grant),        32'(0));
    chk("rst_ready",  32'(req_ready),    32'(0));
    chk("rst_tx",     32'(tft_transmit), 32'(0));
    chk("rst_active", 32'(active),       32'(0));
    chk("rst_tmo",    32'(timeout_err),  32'(0));
    chk("rst_dc",     32'(tft_dc),       32'(0));
    chk("rst_data",   32'(tft_data),     32'(0));
    @(negedge clk);
    rst = 1'b1;

    // 1: single 3-byte burst from requester 1, transmitter idle.
    q[1].push_back('{1'b0, 8'h2A, 1'b0});
    q[1].push_back('{1'b1, 8'h00, 1'b0});
    q[1].push_back('{1'b1, 8'h01, 1'b1});
    txlog.delete();
    run_until_idle(100);
    chk("t1_count", 32'(txlog.size()), 32'(3));
    if (txlog.size() == 3) begin
      chk("t1_gap01", 32'(txlog[1].c - txlog[0].c), 32'(3));
      chk("t1_gap12", 32'(txlog[2].c - txlog[1].c), 32'(3));
      chk("t1_dc0",   32'(txlog[0].dc),   32'(0));
      chk("t1_data0", 32'(txlog[0].data), 32'h2A);
      chk("t1_dc1",   32'(txlog[1].dc),   32'(1));
      chk("t1_data1", 32'(txlog[1].data), 32'h00);
      chk("t1_dc2",   32'(txlog[2].dc),   32'(1));
      chk("t1_data2", 32'(txlog[2].data), 32'h01);
      chk("t1_own",   32'(txlog[2].own),  32'(1));
    end
    chk("t1_grant_after", 32'(grant), 32'(0));

    // 2: requesters 1 and 2 each offer two 2-byte bursts; pointer is now 2.
    burst(1, 2, 8'h10); burst(1, 2, 8'h20);
    burst(2, 2, 8'h30); burst(2, 2, 8'h40);
    txlog.delete();
    run_until_idle(200);
    chk("t2_count", 32'(txlog.size()), 32'(8));
    if (txlog.size() == 8) begin
      int exp_own[8] = '{2, 2, 1, 1, 2, 2, 1, 1};
      for (int k = 0; k < 8; k++) chk("t2_owner", 32'(txlog[k].own), 32'(exp_own[k]));
    end

    // 3: requester 0 raises valid during requester 1's burst; 2 also pending.
    burst(1, 3, 8'h50);
    txlog.delete();
    for (int n = 0; n < 50 && txlog.size() == 0; n++) cyc();
    burst(0, 2, 8'h60);
    burst(2, 1, 8'h70);
    run_until_idle(200);
    chk("t3_count", 32'(txlog.size()), 32'(6));
    if (txlog.size() == 6) begin
      int exp_own[6] = '{1, 1, 1, 0, 0, 2};
      for (int k = 0; k < 6; k++) chk("t3_owner", 32'(txlog[k].own), 32'(exp_own[k]));
    end

    // 4: transmitter busy for 20 cycles after each pulse.
    busy_mode = 1;
    burst(1, 2, 8'h80);
    txlog.delete(); tmolog.delete();
    run_until_idle(200);
    busy_mode = 0;
    chk("t4_count", 32'(txlog.size()), 32'(2));
    if (txlog.size() == 2) chk("t4_spacing", 32'(txlog[1].c - txlog[0].c), 32'(22));
    chk("t4_no_tmo", 32'(tmolog.size()), 32'(0));
    for (int n = 0; n < 25; n++) cyc();

    // 5: requester 2 stalls after one non-last byte; watchdog reclaims.
    q[2].push_back('{1'b1, 8'h55, 1'b0});
    txlog.delete(); tmolog.delete();
    for (int n = 0; n < 50 && grant !== 3'b100; n++) cyc();
    chk("t5_granted", 32'(grant), 32'(3'b100));
    q[1].push_back('{1'b1, 8'h66, 1'b1});
    run_until_idle(200);
    chk("t5_tmo_count", 32'(tmolog.size()), 32'(1));
    chk("t5_tx_count",  32'(txlog.size()),  32'(2));
    if (tmolog.size() == 1 && txlog.size() == 2) begin
      chk("t5_tmo_delay", 32'(tmolog[0] - txlog[0].c), 32'(10));
      chk("t5_next_own",  32'(txlog[1].own), 32'(1));
    end

    // 6: asynchronous reset during the transmit cycle.
    burst(1, 2, 8'h90);
    for (int n = 0; n < 50 && !(m_owner >= 0 && m_ph == 2); n++) cyc();
    chk("t6_in_xmit", 32'(tft_transmit), 32'(1));
    #2 rst = 1'b0;
    #1;
    chk("t6_tx_drop",     32'(tft_transmit), 32'(0));
    chk("t6_grant_drop",  32'(grant),        32'(0));
    chk("t6_active_drop", 32'(active),       32'(0));
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    burst(1, 1, 8'hA0);
    burst(2, 1, 8'hB0);
    txlog.delete();
    run_until_idle(100);
    chk("t6_count", 32'(txlog.size()), 32'(2));
    if (txlog.size() == 2) chk("t6_first_own", 32'(txlog[0].own), 32'(1));

    // Randomized traffic, stalls and busy against the reference.
    rnd_hold = 1; busy_mode = 2;
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        int r;
        r = int'($urandom_range(0, N-1));
        if (q[r].size() < 6) burst(r, int'($urandom_range(1, 4)), 8'($urandom));
      end
      cyc();
    end
    run_until_idle(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
